queue_arbiter: RTL and testbench

Controller that shares the 8-entry byte queue between two producers and one consumer in the 10 kHz domain. It turns level requests into single-cycle `enqueue_in`/`dequeue_in` strobes spaced to respect the queue's internal WAIT/ENQUEUE/DEQUEUE handshake. It never issues an enqueue when the queue is full or a dequeue when it is empty. The queue's FSM would otherwise stall permanently in ENQUEUE or DEQUEUE, so this block is the only legal driver of the queue's control inputs.

---
 rtl/queue_pkg.sv | 27 ++
 rtl/queue_arbiter_if.sv | 41 ++++
 rtl/rr_arbiter2.sv | 52 +++++
 rtl/queue_arbiter.sv | 169 ++++++++++++++++
 tb/tb_queue_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/queue_pkg.sv
// ---------------------------------------------------------------------------
// queue_pkg
// Shared types and constants for the byte-queue arbiter slice.
//   DEF_DEPTH    default queue capacity (entries)
//   DEF_LEN_W    default width of the queue length bus
//   HOLD_CYCLES  cycles one queue operation keeps the controller busy
//   arb_state_t  controller FSM states
//   op_t         last/next operation for enqueue/dequeue alternation
// ---------------------------------------------------------------------------
package queue_pkg;

    localparam int unsigned DEF_DEPTH   = 8;
    localparam int unsigned DEF_LEN_W   = 4;
    localparam int unsigned HOLD_CYCLES = 3;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        DELIVER
    } arb_state_t;

    typedef enum logic {
        OP_ENQ,
        OP_DEQ
    } op_t;

endpackage

// File: rtl/queue_arbiter_if.sv
// ---------------------------------------------------------------------------
// queue_arbiter_if
// Bundles the producer, consumer and queue-control signals of queue_arbiter.
// Modports:
//   slave   the arbiter side (drives acks, rd_valid/rd_data, queue strobes)
//   master  the environment side (producers, consumer and the queue itself)
// Signal names keep the arbiter's point of view (_in into the arbiter).
// ---------------------------------------------------------------------------
interface queue_arbiter_if #(
    parameter int unsigned LEN_W = queue_pkg::DEF_LEN_W
);

    logic             p0_req_in;
    logic [7:0]       p0_data_in;
    logic             p0_ack_out;
    logic             p1_req_in;
    logic [7:0]       p1_data_in;
    logic             p1_ack_out;
    logic             rd_req_in;
    logic             rd_valid_out;
    logic [7:0]       rd_data_out;
    logic [LEN_W-1:0] q_len_in;
    logic [7:0]       q_data_in;
    logic             q_enqueue_out;
    logic             q_dequeue_out;
    logic [7:0]       q_data_out;
    logic             busy_out;

    modport slave (
        input  p0_req_in, p0_data_in, p1_req_in, p1_data_in, rd_req_in, q_len_in, q_data_in,
        output p0_ack_out, p1_ack_out, rd_valid_out, rd_data_out, q_enqueue_out, q_dequeue_out,
               q_data_out, busy_out
    );

    modport master (
        output p0_req_in, p0_data_in, p1_req_in, p1_data_in, rd_req_in, q_len_in, q_data_in,
        input  p0_ack_out, p1_ack_out, rd_valid_out, rd_data_out, q_enqueue_out, q_dequeue_out,
               q_data_out, busy_out
    );

endinterface

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. Grant is combinational from req and the
// priority pointer; the pointer moves past the granted requester on advance.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset (pointer -> requester 0)
//   req      request vector
//   advance  a grant was consumed this cycle
//   grant    one-hot grant (zero when no request)
//   ptr      requester that wins when both request
// ---------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       ptr
);

    logic ptr_q, ptr_d;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        // Granting requester 0 hands priority to 1 and vice versa.
        if (advance && (grant != 2'b00)) begin
            ptr_d = grant[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/queue_arbiter.sv
// ---------------------------------------------------------------------------
// queue_arbiter
// Shares one byte queue between two producers and one consumer. Level
// requests become single-cycle enqueue/dequeue strobes spaced so the queue's
// WAIT/ENQUEUE/DEQUEUE handshake always completes; never enqueues when full
// nor dequeues when empty. All outputs are registered and reset to 0.
// Ports:
//   clock_10KHZ  clock shared with the queue
//   reset        synchronous active-high reset, shared with the queue
//   bus          queue_arbiter_if.slave: producer req/data/ack, consumer
//                req/valid/data, queue len/data in, queue strobes/data out,
//                busy_out
// ---------------------------------------------------------------------------
module queue_arbiter
    import queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic          clock_10KHZ,
    input  logic          reset,
    queue_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_pending_q, rd_pending_d;
    op_t              pref_q, pref_d;
    logic             q_enqueue_q, q_enqueue_d;
    logic             q_dequeue_q, q_dequeue_d;
    logic [7:0]       q_data_q, q_data_d;
    logic             p0_ack_q, p0_ack_d;
    logic             p1_ack_q, p1_ack_d;
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             busy_q, busy_d;

    logic             enq_ok, deq_ok;
    logic [1:0]       rr_req, rr_grant;
    logic             rr_advance, rr_ptr;

    assign rr_req = {bus.p1_req_in, bus.p0_req_in};

    rr_arbiter2 u_rr (
        .clk     (clock_10KHZ),
        .rst     (reset),
        .req     (rr_req),
        .advance (rr_advance),
        .grant   (rr_grant),
        .ptr     (rr_ptr)
    );

    // With both producers asking, the winner must be the pointed-to one.
    always_comb begin
        if (&rr_req) begin
            assert (rr_grant[rr_ptr]);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_pending_d = rd_pending_q;
        pref_d       = pref_q;
        q_enqueue_d  = 1'b0;
        q_dequeue_d  = 1'b0;
        p0_ack_d     = 1'b0;
        p1_ack_d     = 1'b0;
        rd_valid_d   = 1'b0;
        q_data_d     = q_data_q;
        rd_data_d    = rd_data_q;
        busy_d       = busy_q;
        rr_advance   = 1'b0;

        enq_ok = (bus.p0_req_in | bus.p1_req_in) & (bus.q_len_in < LEN_W'(DEPTH));
        deq_ok = bus.rd_req_in & (bus.q_len_in != '0);

        case (state_q)
            IDLE: begin
                // When both are eligible, pref_q holds the opposite of the last grant.
                if (enq_ok && (!deq_ok || (pref_q == OP_ENQ))) begin
                    q_enqueue_d  = 1'b1;
                    q_data_d     = rr_grant[1] ? bus.p1_data_in : bus.p0_data_in;
                    p0_ack_d     = rr_grant[0];
                    p1_ack_d     = rr_grant[1];
                    rr_advance   = 1'b1;
                    busy_d       = 1'b1;
                    cnt_d        = CNT_LOAD;
                    rd_pending_d = 1'b0;
                    pref_d       = OP_DEQ;
                    state_d      = HOLD;
                end else if (deq_ok) begin
                    q_dequeue_d  = 1'b1;
                    busy_d       = 1'b1;
                    cnt_d        = CNT_LOAD;
                    rd_pending_d = 1'b1;
                    pref_d       = OP_ENQ;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                cnt_d = cnt_q - 1'b1;
                // cnt reaches zero on this edge.
                if (cnt_q == CNT_W'(1)) begin
                    if (rd_pending_q) begin
                        state_d = DELIVER;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            DELIVER: begin
                rd_data_d    = bus.q_data_in;
                rd_valid_d   = 1'b1;
                rd_pending_d = 1'b0;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_10KHZ) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rd_pending_q <= 1'b0;
            pref_q       <= OP_ENQ;
            q_enqueue_q  <= 1'b0;
            q_dequeue_q  <= 1'b0;
            q_data_q     <= '0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_pending_q <= rd_pending_d;
            pref_q       <= pref_d;
            q_enqueue_q  <= q_enqueue_d;
            q_dequeue_q  <= q_dequeue_d;
            q_data_q     <= q_data_d;
            p0_ack_q     <= p0_ack_d;
            p1_ack_q     <= p1_ack_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.p0_ack_out    = p0_ack_q;
    assign bus.p1_ack_out    = p1_ack_q;
    assign bus.rd_valid_out  = rd_valid_q;
    assign bus.rd_data_out   = rd_data_q;
    assign bus.q_enqueue_out = q_enqueue_q;
    assign bus.q_dequeue_out = q_dequeue_q;
    assign bus.q_data_out    = q_data_q;
    assign bus.busy_out      = busy_q;

endmodule

// File: tb/tb_queue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_queue_arbiter
// Bench for queue_arbiter with a behavioural 8-entry byte queue attached.
// Expected bytes go into a scoreboard when producer data is offered and are
// popped and compared whenever rd_valid_out appears.
// ---------------------------------------------------------------------------
module tb_queue_arbiter;
    import queue_pkg::*;

    localparam int unsigned DEPTH = DEF_DEPTH;
    localparam int unsigned LEN_W = DEF_LEN_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    queue_arbiter_if #(.LEN_W(LEN_W)) bus ();

    queue_arbiter #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clock_10KHZ (clk),
        .reset       (rst),
        .bus         (bus)
    );

    // Behavioural queue: strobe sampled at E+1, update at E+2, WAIT at E+3.
    typedef enum logic [1:0] {QWAIT, QENQ, QDEQ, QRET} qst_t;
    qst_t             qst;
    logic [7:0]       mem [DEPTH];
    int               head, tail;
    logic [LEN_W-1:0] qlen;
    logic [7:0]       qdout;
    int               viol = 0;

    always @(posedge clk) begin
        if (rst) begin
            qst   <= QWAIT;
            head  <= 0;
            tail  <= 0;
            qlen  <= '0;
            qdout <= '0;
        end else begin
            case (qst)
                QWAIT: begin
                    if (bus.q_enqueue_out) begin
                        if (qlen == LEN_W'(DEPTH)) viol <= viol + 1;
                        qst <= QENQ;
                    end else if (bus.q_dequeue_out) begin
                        if (qlen == '0) viol <= viol + 1;
                        qst <= QDEQ;
                    end
                end
                QENQ: begin
                    if (bus.q_enqueue_out || bus.q_dequeue_out) viol <= viol + 1;
                    if (qlen < LEN_W'(DEPTH)) begin
                        mem[tail] <= bus.q_data_out;
                        tail      <= (tail + 1) % DEPTH;
                        qlen      <= qlen + 1'b1;
                    end
                    qst <= QRET;
                end
                QDEQ: begin
                    if (bus.q_enqueue_out || bus.q_dequeue_out) viol <= viol + 1;
                    if (qlen != '0) begin
                        qdout <= mem[head];
                        head  <= (head + 1) % DEPTH;
                        qlen  <= qlen - 1'b1;
                    end
                    qst <= QRET;
                end
                default: begin
                    if (bus.q_enqueue_out || bus.q_dequeue_out) viol <= viol + 1;
                    qst <= QWAIT;
                end
            endcase
        end
    end

    assign bus.q_len_in  = qlen;
    assign bus.q_data_in = qdout;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [7:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic sel_sig(input int s);
        case (s)
            0:       return bus.p0_ack_out;
            1:       return bus.p1_ack_out;
            2:       return bus.rd_valid_out;
            3:       return bus.q_enqueue_out;
            4:       return bus.q_dequeue_out;
            5:       return bus.p0_ack_out | bus.p1_ack_out;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int s, input int max, output logic found);
        found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            step();
            found = sel_sig(s);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.p0_req_in  = 1'b0;
        bus.p1_req_in  = 1'b0;
        bus.rd_req_in  = 1'b0;
        bus.p0_data_in = '0;
        bus.p1_data_in = '0;
        step();
        step();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic enq_byte(input int p, input logic [7:0] d);
        logic found;
        if (p == 0) begin
            bus.p0_req_in  = 1'b1;
            bus.p0_data_in = d;
        end else begin
            bus.p1_req_in  = 1'b1;
            bus.p1_data_in = d;
        end
        sb.push_back(d);
        wait_for(p, 10, found);
        chk("enq ack seen", 32'(found), 32'd1);
        if (p == 0) bus.p0_req_in = 1'b0;
        else        bus.p1_req_in = 1'b0;
    endtask

    task automatic rd_check(input string tag);
        logic       found;
        logic [7:0] exp;
        wait_for(2, 12, found);
        chk({tag, " rd_valid seen"}, 32'(found), 32'd1);
        exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        chk({tag, " rd_data"}, 32'(bus.rd_data_out), 32'(exp));
    endtask

    function automatic logic [31:0] all_outs();
        return {8'h00, bus.q_enqueue_out, bus.q_dequeue_out, bus.p0_ack_out, bus.p1_ack_out,
                bus.rd_valid_out, bus.busy_out, 2'b00, bus.q_data_out, bus.rd_data_out};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        logic early;
        int   t_last;
        int   nops;
        int   cnt;
        logic [1:0] exp_who;

        // ---- 1: reset state and a single p0 enqueue ----
        do_reset();
        chk("reset outputs", all_outs(), 32'd0);
        chk("reset state", 32'(dut.state_q), 32'(IDLE));
        bus.p0_req_in  = 1'b1;
        bus.p0_data_in = 8'hA5;
        step();
        chk("t1 p0_ack at E", 32'(bus.p0_ack_out), 32'd1);
        chk("t1 p1_ack at E", 32'(bus.p1_ack_out), 32'd0);
        chk("t1 enqueue at E", 32'(bus.q_enqueue_out), 32'd1);
        chk("t1 q_data at E", 32'(bus.q_data_out), 32'hA5);
        chk("t1 busy at E", 32'(bus.busy_out), 32'd1);
        bus.p0_req_in = 1'b0;
        step();
        chk("t1 enqueue E+1", 32'(bus.q_enqueue_out), 32'd0);
        chk("t1 ack E+1", 32'(bus.p0_ack_out), 32'd0);
        chk("t1 busy E+1", 32'(bus.busy_out), 32'd1);
        step();
        chk("t1 len E+2", 32'(qlen), 32'd1);
        step();
        chk("t1 busy E+3", 32'(bus.busy_out), 32'd0);

        // ---- 2: both producers hold req, round-robin p0,p1,p0 ----
        do_reset();
        bus.p0_req_in  = 1'b1;
        bus.p0_data_in = 8'h11;
        bus.p1_req_in  = 1'b1;
        bus.p1_data_in = 8'h22;
        t_last = 0;
        for (int k = 0; k < 3; k++) begin
            wait_for(5, 10, found);
            chk("t2 ack seen", 32'(found), 32'd1);
            if (k > 0) chk("t2 ack spacing", 32'(cyc - t_last), 32'd3);
            t_last  = cyc;
            exp_who = (k == 1) ? 2'b10 : 2'b01;
            chk("t2 winner", 32'({bus.p1_ack_out, bus.p0_ack_out}), 32'(exp_who));
            sb.push_back((k == 1) ? 8'h22 : 8'h11);
        end
        bus.p0_req_in = 1'b0;
        bus.p1_req_in = 1'b0;
        repeat (3) step();
        chk("t2 len", 32'(qlen), 32'd3);
        bus.rd_req_in = 1'b1;
        for (int k = 0; k < 3; k++) rd_check("t2 drain");
        bus.rd_req_in = 1'b0;
        step();
        chk("t2 rd_valid one cycle", 32'(bus.rd_valid_out), 32'd0);

        // ---- 3: full queue, p1 waits, dequeue proceeds ----
        do_reset();
        for (int i = 0; i < 8; i++) enq_byte(0, 8'h40 + 8'(i));
        repeat (3) step();
        chk("t3 len full", 32'(qlen), 32'd8);
        bus.p1_req_in  = 1'b1;
        bus.p1_data_in = 8'h77;
        bus.rd_req_in  = 1'b1;
        found = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (bus.p1_ack_out) early = 1'b1;
            found = bus.rd_valid_out;
        end
        chk("t3 rd_valid seen", 32'(found), 32'd1);
        chk("t3 no ack while full", 32'(early), 32'd0);
        chk("t3 head byte", 32'(bus.rd_data_out), 32'(sb.pop_front()));
        bus.rd_req_in = 1'b0;
        wait_for(1, 8, found);
        chk("t3 p1 acked after deq", 32'(found), 32'd1);
        sb.push_back(8'h77);
        bus.p1_req_in = 1'b0;
        repeat (3) step();
        chk("t3 len refilled", 32'(qlen), 32'd8);
        bus.rd_req_in = 1'b1;
        for (int k = 0; k < 8; k++) rd_check("t3 drain");
        bus.rd_req_in = 1'b0;

        // ---- 4: read on empty waits, then follows an enqueue ----
        do_reset();
        bus.rd_req_in = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.q_dequeue_out) cnt++;
        end
        chk("t4 no deq when empty", 32'(cnt), 32'd0);
        enq_byte(0, 8'h3C);
        rd_check("t4");
        bus.rd_req_in = 1'b0;

        // ---- 5: enqueue/dequeue alternation around len 4 ----
        do_reset();
        for (int i = 0; i < 5; i++) enq_byte(0, 8'h50 + 8'(i));
        repeat (3) step();
        bus.rd_req_in = 1'b1;
        rd_check("t5 pre");
        bus.rd_req_in  = 1'b0;
        bus.p1_req_in  = 1'b1;
        bus.p1_data_in = 8'h60;
        bus.rd_req_in  = 1'b1;
        nops = 0;
        for (int i = 0; i < 60 && nops < 6; i++) begin
            step();
            if (bus.rd_valid_out) begin
                chk("t5 rd_data", 32'(bus.rd_data_out), 32'(sb.pop_front()));
            end
            if (bus.q_enqueue_out || bus.q_dequeue_out) begin
                chk("t5 op order", 32'(bus.q_enqueue_out), 32'((nops % 2) == 0));
                chk("t5 len at op", 32'(qlen), (nops % 2 == 0) ? 32'd4 : 32'd5);
                if (bus.q_enqueue_out) sb.push_back(8'h60);
                nops++;
            end
        end
        chk("t5 op count", 32'(nops), 32'd6);
        bus.p1_req_in = 1'b0;
        bus.rd_req_in = 1'b0;
        rd_check("t5 last");

        // ---- 6: reset while a dequeue is in flight ----
        do_reset();
        enq_byte(0, 8'h99);
        repeat (3) step();
        bus.rd_req_in = 1'b1;
        wait_for(4, 8, found);
        chk("t6 deq grant", 32'(found), 32'd1);
        step();
        rst = 1'b1;
        step();
        chk("t6 outputs after reset", all_outs(), 32'd0);
        chk("t6 state after reset", 32'(dut.state_q), 32'(IDLE));
        rst           = 1'b0;
        bus.rd_req_in = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.rd_valid_out || bus.p0_ack_out || bus.p1_ack_out || bus.q_enqueue_out
                || bus.q_dequeue_out) cnt++;
        end
        chk("t6 silent after reset", 32'(cnt), 32'd0);

        chk("queue protocol violations", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
